// File: rtl/fsm_multi_hold_ctrl.sv
// Hold-to-confirm controller: NCH request channels share one down-counter.
// A granted channel must hold X high for DELAY+1 cycles before its Y pulse fires.
module fsm_multi_hold_ctrl #(
    parameter  int NCH       = 4,
    parameter  int CW        = 8,
    parameter  int PULSE_LEN = 1,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CLK,
    input  logic           N_RESET,
    input  logic [NCH-1:0] X,
    input  logic [CW-1:0]  DELAY,
    output logic [NCH-1:0] Y,
    output logic           TRST,
    output logic           TSTART,
    output logic           BUSY,
    output logic [CHW-1:0] CH,
    output logic [CW-1:0]  COUNT,
    output logic           ABORT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);

    state_t         state;
    state_t         state_next;
    logic [NCH-1:0] armed;
    logic [NCH-1:0] eligible;
    logic [NCH-1:0] ch_onehot;
    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] grant_idx;
    logic           grant_found;
    logic [7:0]     pcnt;
    logic           held;

    assign eligible  = X & armed;
    assign ch_onehot = NCH'(1) << CH;
    assign held      = X[CH];

    // Round-robin search: lowest offset from rr_ptr wins, so scan offsets downward.
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CHW'(idx);
            end
        end
    end

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (grant_found) state_next = START;
            START: state_next = HOLD;
            HOLD: begin
                if (!held)              state_next = IDLE;
                else if (COUNT == '0)   state_next = DONE;
            end
            DONE:  if (pcnt == PULSE_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign Y      = (state == DONE) ? ch_onehot : '0;
    assign TRST   = (state == IDLE);
    assign TSTART = (state == START);
    assign BUSY   = (state != IDLE);

    // A low X re-arms its channel even in START, so the clear only sticks while X stays high.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            CH     <= '0;
            COUNT  <= '0;
            ABORT  <= 1'b0;
            armed  <= '1;
            rr_ptr <= '0;
            pcnt   <= '0;
        end else begin
            armed <= (armed & ~((state == START) ? ch_onehot : '0)) | ~X;
            ABORT <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) CH <= grant_idx;
                    pcnt <= '0;
                end
                START: begin
                    COUNT  <= DELAY;
                    rr_ptr <= CHW'((int'(CH) + 1) % NCH);
                end
                HOLD: begin
                    if (!held)                ABORT <= 1'b1;
                    else if (COUNT != '0)     COUNT <= COUNT - 1'b1;
                end
                DONE: pcnt <= (pcnt == PULSE_LAST) ? '0 : pcnt + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_multi_hold_ctrl.sv
// Randomised bench for fsm_multi_hold_ctrl against a request-level reference
// model tracking grant, elapsed hold time and emitted pulses.
module tb_fsm_multi_hold_ctrl;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int PL  = 3;

    logic           CLK = 1'b0;
    logic           N_RESET;
    logic [NCH-1:0] X;
    logic [CW-1:0]  DELAY;
    logic [NCH-1:0] Y;
    logic           TRST, TSTART, BUSY, ABORT;
    logic [1:0]     CH;
    logic [CW-1:0]  COUNT;

    int vectors = 0;
    int miscompares = 0;

    // Reference: phase 0 idle, 1 granted, 2 holding, 3 pulsing.
    int       m_phase;
    int       m_ch;
    int       m_rr;
    int       m_delay;
    int       m_elapsed;
    int       m_pulses;
    bit       m_abort;
    bit [3:0] m_armed;

    fsm_multi_hold_ctrl #(.NCH(NCH), .CW(CW), .PULSE_LEN(PL)) dut (
        .CLK(CLK), .N_RESET(N_RESET), .X(X), .DELAY(DELAY), .Y(Y),
        .TRST(TRST), .TSTART(TSTART), .BUSY(BUSY), .CH(CH), .COUNT(COUNT),
        .ABORT(ABORT)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_phase = 0; m_ch = 0; m_rr = 0; m_delay = 0; m_elapsed = 0;
        m_pulses = 0; m_abort = 0; m_armed = 4'hF;
    endtask

    task automatic modelStep();
        bit [3:0] nextArmed;
        bit found;
        int idx;
        for (int i = 0; i < NCH; i++)
            nextArmed[i] = !X[i] ? 1'b1 : ((m_phase == 1 && m_ch == i) ? 1'b0 : m_armed[i]);
        m_abort = 0;
        case (m_phase)
            0: begin
                found = 0;
                for (int k = 0; k < NCH; k++) begin
                    idx = (m_rr + k) % NCH;
                    if (!found && X[idx] && m_armed[idx]) begin
                        found = 1; m_ch = idx; m_phase = 1;
                    end
                end
            end
            1: begin
                m_delay = int'(DELAY); m_elapsed = 0;
                m_rr = (m_ch + 1) % NCH; m_phase = 2;
            end
            2: begin
                if (!X[m_ch]) begin
                    m_phase = 0; m_abort = 1;
                end else if (m_elapsed == m_delay) begin
                    m_phase = 3; m_pulses = 0;
                end else m_elapsed++;
            end
            default: begin
                m_pulses++;
                if (m_pulses == PL) m_phase = 0;
            end
        endcase
        m_armed = nextArmed;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".Y"},      32'(Y),      (m_phase == 3) ? (32'd1 << m_ch) : 32'd0);
        checkOutput({tag, ".TRST"},   32'(TRST),   32'(m_phase == 0));
        checkOutput({tag, ".TSTART"}, 32'(TSTART), 32'(m_phase == 1));
        checkOutput({tag, ".BUSY"},   32'(BUSY),   32'(m_phase != 0));
        checkOutput({tag, ".CH"},     32'(CH),     32'(m_ch));
        checkOutput({tag, ".COUNT"},  32'(COUNT),  32'(m_delay - m_elapsed));
        checkOutput({tag, ".ABORT"},  32'(ABORT),  32'(m_abort));
    endtask

    task automatic applyStimulus(input string tag, input logic [3:0] x, input logic [7:0] d);
        @(negedge CLK);
        compareAll(tag);
        X = x;
        DELAY = d;
        @(posedge CLK);
        modelStep();
    endtask

    task automatic releaseReset();
        @(negedge CLK);
        compareAll("reset");
        N_RESET = 1'b1;
        X = '0;
        @(posedge CLK);
        modelStep();
    endtask

    initial begin
        logic [3:0] xr;
        N_RESET = 1'b0;
        X = '0;
        DELAY = '0;
        modelReset();
        repeat (2) @(posedge CLK);
        releaseReset();

        // single channel, then no re-fire while held
        repeat (14) applyStimulus("single", 4'b0100, 8'd3);
        repeat (2)  applyStimulus("single", 4'b0000, 8'd3);

        // abort on third hold cycle, then full rerun
        repeat (4)  applyStimulus("abort", 4'b0010, 8'd5);
        repeat (3)  applyStimulus("abort", 4'b0000, 8'd5);
        repeat (14) applyStimulus("abort", 4'b0010, 8'd5);
        repeat (2)  applyStimulus("abort", 4'b0000, 8'd5);

        // round robin with each channel dropping for one cycle
        for (int r = 0; r < 5; r++) begin
            repeat (9) applyStimulus("rr", 4'hF, 8'd1);
            applyStimulus("rr", 4'hF & ~(4'b0001 << (r % NCH)), 8'd1);
        end
        repeat (8) applyStimulus("rr", 4'h0, 8'd1);

        // delay boundaries
        repeat (8)   applyStimulus("dly0", 4'b1000, 8'd0);
        repeat (2)   applyStimulus("dly0", 4'b0000, 8'd0);
        repeat (264) applyStimulus("dlymax", 4'b0001, 8'hFF);
        repeat (2)   applyStimulus("dlymax", 4'b0000, 8'hFF);

        // drop X exactly when COUNT reaches zero
        repeat (4) applyStimulus("simul", 4'b1000, 8'd2);
        repeat (4) applyStimulus("simul", 4'b0000, 8'd2);

        // asynchronous reset in the middle of a hold on channel 2
        repeat (5) applyStimulus("midrst", 4'b0100, 8'd20);
        @(negedge CLK);
        #1 N_RESET = 1'b0;
        #1;
        checkOutput("async.Y",     32'(Y),      32'd0);
        checkOutput("async.BUSY",  32'(BUSY),   32'd0);
        checkOutput("async.TRST",  32'(TRST),   32'd1);
        checkOutput("async.COUNT", 32'(COUNT),  32'd0);
        checkOutput("async.CH",    32'(CH),     32'd0);
        checkOutput("async.ABORT", 32'(ABORT),  32'd0);
        modelReset();
        X = '0;
        releaseReset();

        // random traffic
        xr = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < NCH; b++)
                if ($urandom_range(0, 7) == 0) xr[b] = ~xr[b];
            applyStimulus("rand", xr, 8'($urandom_range(0, 12)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fsm_multi_hold_ctrl.md
Name: fsm_multi_hold_ctrl

Overview:
- Moore-style hold-to-confirm controller serving NCH request channels through a single shared internal down-counter.
- A channel holding X[i] high is granted round-robin, must stay high for DELAY+1 hold cycles, then receives a Y[i] pulse of PULSE_LEN cycles.
- Dropping X during the hold aborts the request.
- Sits between debounced request inputs and downstream action logic; generalises the single-channel IDLE/START/HOLD/DONE controller with its external timer.

Parameters:
NCH, 4, number of request channels (>=2)
CW, 8, width of DELAY and internal counter
PULSE_LEN, 1, number of cycles Y[i] is held high in DONE (>=1, <=255)

Ports:
CLK  in  1  clock, rising edge
N_RESET  in  1  asynchronous active-low reset
X  in  NCH  per-channel request level
DELAY  in  CW  hold length; sampled only in START
Y  out  NCH  one-hot completion pulse for the granted channel
TRST  out  1  high in IDLE (timer-reset indication)
TSTART  out  1  high in START only
BUSY  out  1  high in any state other than IDLE
CH  out  $clog2(NCH)  currently / last granted channel index
COUNT  out  CW  live counter value
ABORT  out  1  one-cycle pulse on the first IDLE cycle after an aborted hold

Behaviour:
- Reset is asynchronous; CLK is the clock. Reset values:
  - state=IDLE
  - Y=0, TSTART=0, BUSY=0, ABORT=0, TRST=1
  - CH=0, COUNT=0
  - armed[NCH-1:0]=all 1
  - round-robin pointer gives channel 0 highest priority first.
- States: IDLE, START, HOLD, DONE. Outputs Y, TRST, TSTART, BUSY decode from state only (Moore); CH, COUNT, ABORT are registers.
- IDLE:
  - eligible[i] = X[i] & armed[i].
  - If any channel is eligible, grant the first eligible index at or after rr_ptr (wrapping), latch CH, go to START.
- START (1 cycle): COUNT<=DELAY, armed[CH]<=0, rr_ptr<=CH+1 mod NCH, go to HOLD.
- HOLD, evaluated each cycle in this priority order:
  - X[CH]==0: go to IDLE, assert ABORT next cycle.
  - COUNT==0: go to DONE.
  - Otherwise COUNT<=COUNT-1.
  - Resulting HOLD length is DELAY+1 cycles. DELAY=0 gives a single HOLD cycle. Abort beats completion in the same cycle.
- DONE: Y[CH]=1 for exactly PULSE_LEN cycles (internal pulse counter), then go to IDLE. X is ignored in DONE.
- Latency: X[i] first high in IDLE at cycle t gives START at t+1, HOLD from t+2, and Y[i] from t+DELAY+3 (if uncontested and held).
- Re-arm:
  - Every cycle, in any state, armed[i]<=1 whenever X[i]==0.
  - A channel held high continuously therefore fires once only; it must drop X for at least one cycle to request again.
  - Re-arm of a non-granted channel is unaffected by the grant.
- Other channels' X changes during START/HOLD/DONE do not disturb the active channel; they are arbitrated on the next IDLE cycle.
- An aborted channel is disarmed until its X is low, which it already is at abort.
- Every return to IDLE spends at least one IDLE cycle (TRST=1) before the next START.
- COUNT wraps never: decrement happens only when COUNT!=0.
- Reset mid-operation: immediate return to the reset values above. No Y or ABORT glitch is permitted after N_RESET falls.

Test Plan:
- Reset: N_RESET low mid-HOLD -> Y=0, BUSY=0, TRST=1, COUNT=0, CH=0 asynchronously; state IDLE after release.
- Single channel: DELAY=3, X[2] rises at cycle t and stays high -> TSTART at t+1, COUNT 3,2,1,0, Y=4'b0100 at t+6 for PULSE_LEN cycles, then no second pulse while X[2] stays high.
- Abort: DELAY=5, X[1] drops on the third HOLD cycle -> no Y; ABORT pulses one cycle in IDLE; X[1] re-raised -> a new full sequence runs.
- Round-robin: X=4'b1111 held, each channel toggled low for one cycle after its pulse -> grant order 0,1,2,3,0 and CH tracks it.
- Boundary: DELAY=0 -> exactly one HOLD cycle, Y at t+3. DELAY=2^CW-1 -> HOLD lasts 2^CW cycles with no COUNT wrap.
- Simultaneous: X[CH] falls in the cycle COUNT==0 -> abort taken, no Y. PULSE_LEN=3 -> Y held exactly 3 cycles.
